// File: rtl/frac_rsp_buffer_if.sv
// rtl/frac_rsp_buffer_if.sv - request/response handshake bundle for frac_rsp_buffer
interface frac_rsp_buffer_if #(
  parameter int DATA_Width = 8,
  parameter int DEPTH      = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  req_valid;
  logic                  req_ready;
  logic                  mem_rd;
  logic [DATA_Width-1:0] rsp_din;
  logic [DATA_Width-1:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic [CW-1:0]         count;

  // Buffer side: takes requests and source data, presents the FIFO head.
  modport slave (
    input  req_valid, rsp_din, dout_ready,
    output req_ready, mem_rd, dout, dout_valid, count
  );

  // Upstream/source/downstream side.
  modport master (
    output req_valid, rsp_din, dout_ready,
    input  req_ready, mem_rd, dout, dout_valid, count
  );
endinterface

// File: rtl/frac_rsp_buffer.sv
// rtl/frac_rsp_buffer.sv - credit-issued read buffer for a fixed-latency source; FRAC_FLUSH_EN adds flush
module frac_rsp_buffer #(
  parameter int LATENCY    = 7,
  parameter int DATA_Width = 8,
  parameter int DEPTH      = 16
) (
  input logic clk,
  input logic rst,
  frac_rsp_buffer_if.slave bus
`ifdef FRAC_FLUSH_EN
  ,
  input logic flush
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_Width-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         credits;
  logic [LATENCY-1:0]    vld_sr;
  logic [LATENCY:0]      vld_ext;
  logic                  req_ok;
  logic                  issue;
  logic                  has_data;
  logic                  pop;
  logic                  push;

  // Bit 0 is this cycle's strobe; the top bit marks the return landing this cycle.
  assign vld_ext  = {vld_sr, issue};
  assign has_data = (cnt != '0);

`ifdef FRAC_FLUSH_EN
  assign req_ok = rst & ~flush & (credits < CW'(DEPTH));
  assign pop    = has_data & bus.dout_ready & ~flush;
  assign push   = vld_ext[LATENCY] & ~flush;
`else
  assign req_ok = rst & (credits < CW'(DEPTH));
  assign pop    = has_data & bus.dout_ready;
  assign push   = vld_ext[LATENCY];
`endif

  assign issue          = bus.req_valid & req_ok;
  assign bus.req_ready  = req_ok;
  assign bus.mem_rd     = issue;
  assign bus.dout_valid = has_data;
  assign bus.count      = cnt;
  // Empty slots may hold stale data; show zero instead.
  assign bus.dout       = has_data ? mem[rd_ptr] : '0;

  // In-flight tracker: one bit per outstanding read, shifted toward the return slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      vld_sr <= '0;
`ifdef FRAC_FLUSH_EN
    else if (flush)
      vld_sr <= '0;
`endif
    else
      vld_sr <= vld_ext[LATENCY-1:0];
  end

  // Credits count in-flight plus stored entries, so a return always finds a free slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      credits <= '0;
`ifdef FRAC_FLUSH_EN
    else if (flush)
      credits <= '0;
`endif
    else begin
      case ({issue, pop})
        2'b10:   credits <= credits + CW'(1);
        2'b01:   credits <= credits - CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  // FIFO pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end
`ifdef FRAC_FLUSH_EN
    else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end
`endif
    else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Capture the source return into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.rsp_din;
  end

  // The credit scheme must never let a return arrive at a full FIFO.
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst) !(push && cnt == CW'(DEPTH)))
    else $error("push into full FIFO");

endmodule

// File: tb/tb_frac_rsp_buffer.sv
// tb/tb_frac_rsp_buffer.sv - randomized queue-model bench for frac_rsp_buffer
module tb_frac_rsp_buffer;
  localparam int LATENCY = 7;
  localparam int DEPTH   = 16;
  localparam int W       = 8;

  typedef struct {
    int         due;
    logic [7:0] data;
  } pend_t;

  logic clk = 1'b0;
  logic rst;
`ifdef FRAC_FLUSH_EN
  logic flush;
`endif

  always #5 clk = ~clk;

  frac_rsp_buffer_if #(.DATA_Width(W), .DEPTH(DEPTH)) bus ();

  frac_rsp_buffer #(.LATENCY(LATENCY), .DATA_Width(W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FRAC_FLUSH_EN
    ,
    .flush (flush)
`endif
  );

  pend_t      pend[$];
  logic [7:0] fifo_q[$];
  int         cyc;
  int         n_cmp;
  int         n_err;
  int         n_rd;
  int         n_pop;
  int         issue_idx;
  int         data_mode;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive at negedge, check, then advance the model at posedge.
  task automatic step(input bit rv, input bit dr, input bit fl);
    bit         exp_ready;
    bit         issue;
    bit         pop;
    logic [7:0] d;
    bus.req_valid  = rv;
    bus.dout_ready = dr;
`ifdef FRAC_FLUSH_EN
    flush = fl;
`endif
    if (pend.size() > 0 && pend[0].due == cyc) bus.rsp_din = pend[0].data;
    else bus.rsp_din = 8'($urandom);
    #1;
    exp_ready = !fl && (pend.size() + fifo_q.size() < DEPTH);
    issue     = rv && exp_ready;
    pop       = !fl && fifo_q.size() > 0 && dr;
    check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    check("mem_rd", 32'(bus.mem_rd), 32'(issue));
    check("dout_valid", 32'(bus.dout_valid), 32'(fifo_q.size() != 0));
    check("count", 32'(bus.count), 32'(fifo_q.size()));
    check("dout", 32'(bus.dout), (fifo_q.size() != 0) ? 32'(fifo_q[0]) : 32'd0);
    n_rd  += int'(bus.mem_rd);
    n_pop += int'(bus.dout_valid && dr);
    @(posedge clk);
    if (fl) begin
      pend.delete();
      fifo_q.delete();
    end else begin
      if (pop) void'(fifo_q.pop_front());
      if (pend.size() > 0 && pend[0].due == cyc) fifo_q.push_back(pend.pop_front().data);
      if (issue) begin
        case (data_mode)
          1:       d = 8'(issue_idx);
          2:       d = 8'hA5;
          default: d = 8'($urandom);
        endcase
        issue_idx++;
        pend.push_back('{cyc + LATENCY, d});
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic reset_phase(input int cycles);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 1'b1;
    #1;
    pend.delete();
    fifo_q.delete();
    check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'd0);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      cyc++;
      check("rst_hold_mem_rd", 32'(bus.mem_rd), 32'd0);
    end
    rst = 1'b1;
  endtask

  initial begin
    int c0;
    int m0;
    int m1;
    n_cmp = 0; n_err = 0; n_rd = 0; n_pop = 0; cyc = 0; issue_idx = 0; data_mode = 0;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    bus.dout_ready = 1'b0;
    bus.rsp_din = '0;
`ifdef FRAC_FLUSH_EN
    flush = 1'b0;
`endif
    reset_phase(3);

    // Single read: end-to-end latency and captured value.
    step(0, 0, 0);
    data_mode = 2;
    c0 = cyc;
    step(1, 0, 0);
    data_mode = 0;
    while (!bus.dout_valid && cyc < c0 + 30) step(0, 0, 0);
    check("single_latency", 32'(cyc - c0), 32'(LATENCY + 1));
    check("single_dout", 32'(bus.dout), 32'hA5);
    check("single_count", 32'(bus.count), 32'd1);
    step(0, 1, 0);
    step(0, 0, 0);

    // Back-pressure: credits cap issue at DEPTH.
    n_rd = 0;
    for (int i = 0; i < 40; i++) step(1, 0, 0);
    check("bp_issues", 32'(n_rd), 32'(DEPTH));
    check("bp_count", 32'(bus.count), 32'(DEPTH));
    m0 = n_rd;
    step(1, 1, 0);
    m1 = n_rd;
    step(1, 1, 0);
    check("bp_no_issue_on_first_pop", 32'(m1 - m0), 32'd0);
    check("bp_issue_after_pop", 32'(n_rd - m1), 32'd1);
    for (int i = 0; i < 40; i++) step(0, 1, 0);

    // Streaming: one issue and one pop per cycle, data = issue index.
    data_mode = 1;
    issue_idx = 0;
    n_rd = 0;
    n_pop = 0;
    for (int i = 0; i < 100; i++) step(1, 1, 0);
    check("stream_issues", 32'(n_rd), 32'd100);
    for (int i = 0; i < 20; i++) step(0, 1, 0);
    check("stream_pops", 32'(n_pop), 32'd100);
    data_mode = 0;

`ifdef FRAC_FLUSH_EN
    // Flush with 3 stored and 5 in flight.
    for (int i = 0; i < 8; i++) step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    check("pre_flush_count", 32'(bus.count), 32'd3);
    step(1, 1, 1);
    check("flush_count", 32'(bus.count), 32'd0);
    check("flush_dout_valid", 32'(bus.dout_valid), 32'd0);
    check("flush_req_ready", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    check("flush_late_dropped", 32'(bus.count), 32'd0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
`ifdef FRAC_FLUSH_EN
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), $urandom_range(0, 99) == 0);
`else
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), 1'b0);
`endif
    end

    // Mid-operation reset drops everything in flight.
    reset_phase(2);
    for (int i = 0; i < 200; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 30; i++) step(0, 1, 0);
    check("final_count", 32'(bus.count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end
endmodule
